u_lsu_store_buffer: RTL and testbench
=====================================

# u_lsu_store_buffer

Store buffer between the LSU store data extensor and the data memory write port. It accepts line-wide store requests: a 128-bit write data line plus a 128-bit per-bit write enable. It queues them in a small in-order FIFO, merging consecutive stores to the same line, and drains them to Dmem over a valid/ready handshake. It also gives IEX a line-granular hazard check so that loads never bypass pending stores.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_W, `DATA_MEM_WIDTH_BIT, byte address width.
- OFF_W, 4, line offset bits, equal to log2(`DATA_MEM_WIDTH/8).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, clock.
  - rst_n, input, 1, asynchronous active-low reset.
- Store request input:
  - st_valid, input, 1, store request from the extensor stage (pipe valid already applied).
  - st_ready, output, 1, buffer can accept or merge this cycle.
  - st_addr, input, ADDR_W, byte address of the store; only [ADDR_W-1:OFF_W] is used.
  - st_wr_data, input, `DATA_MEM_WIDTH, replicated store data line.
  - st_wen, input, `DATA_MEM_WIDTH, per-bit write enable.
- Dmem write port:
  - mem_valid, output, 1, head entry presented to Dmem.
  - mem_ready, input, 1, Dmem accepts the head this cycle.
  - mem_line, output, ADDR_W-OFF_W, line index of the head.
  - mem_wr_data, output, `DATA_MEM_WIDTH, head data.
  - mem_wen, output, `DATA_MEM_WIDTH, head bit enables.
- Load hazard check and status:
  - ld_chk_valid, input, 1, load in IEX requests a hazard check.
  - ld_chk_addr, input, ADDR_W, load byte address.
  - ld_hit, output, 1, combinational; a pending entry matches the load line.
  - sb_empty, output, 1, no pending entries (used for fence and halt).
  - sb_count, output, log2(DEPTH)+1, number of valid entries.

## Operation
Storage:
- Circular FIFO with wr_ptr, rd_ptr and count. Each entry holds {line, data, wen}.
- Outputs mem_valid, mem_line, mem_wr_data and mem_wen come directly from the head registers.

Enqueue (st_valid && st_ready):
- st_wen == 0: the request is accepted and dropped; no allocation.
- Merge: if count >= 2 and the tail line equals the store line, the store merges into the tail.
  - new data = (old_data & ~st_wen) | (st_wr_data & st_wen).
  - new wen = old_wen | st_wen.
  - count is unchanged.
- Otherwise a new entry is allocated at wr_ptr and count is incremented.

Merge restrictions:
- A merge is never made into the head entry. This keeps the head stable while mem_valid is high.

Dequeue:
- When mem_valid && mem_ready, the head retires, rd_ptr advances and count is decremented.

st_ready:
- st_ready = (count < DEPTH) || merge-eligible.
- When full, a same-line merge into the tail is still accepted.

Simultaneous enqueue and dequeue:
- Both take effect in the same cycle; count is unchanged.
- When full, the freed slot is not reused in the same cycle: st_ready depends only on registered count, with no combinational path from mem_ready.

Hazard check:
- ld_hit = ld_chk_valid && OR over valid entries of (entry.line == ld_chk_addr[ADDR_W-1:OFF_W]).
- The check is line-granular and ignores wen overlap. IEX stalls the load while ld_hit is high.

Pointer wrap:
- Pointers are log2(DEPTH) bits and wrap naturally.
- Full and empty are decided from count, not from pointer comparison.

## Timing
Reset values:
- count=0, pointers=0, all entry fields=0.
- mem_valid=0, st_ready=1, sb_empty=1, sb_count=0, ld_hit=0.

Reset mid-operation:
- All pending stores are discarded. mem_valid drops asynchronously with rst_n.

Latency:
- A store accepted at edge N appears on mem_valid after edge N (at earliest) when the buffer was empty.

Throughput:
- One enqueue per cycle and one drain per cycle, sustained.

Handshake:
- Once mem_valid is high, mem_line, mem_wr_data and mem_wen hold stable until the mem_ready cycle.
- mem_valid never deasserts without a handshake, except on reset.

Load check timing:
- ld_hit reflects registered entries only; a store in the same cycle is not visible.
- The pipeline guarantees one cycle of store-to-load ordering through its IEX stall.

## Structure
Shared LSU defines:
- `DATA_MEM_WIDTH, `DATA_MEM_WIDTH_BIT.
- New `LSU_LINE_OFF_BITS (4).
- New `LSU_SB_DEPTH (4).

Sub-module:
- u_lsu_sb_merge, a combinational bit-merge of {data, wen} pairs.
- Reused for tail merging. It is a natural candidate for a future load-forwarding path.

## Test plan
1. Single store: st_addr=0x24, wen=bits[63:32] set, data=0xDEADBEEF replicated. Expected: mem_valid at N+1, mem_line=0x2, mem_wen=bits[63:32]. Hold mem_ready=0 for 3 cycles; the outputs must stay stable and drain on mem_ready=1.
2. Merge: with mem_ready=0, store line 0x1, then sb to line 0x5 byte 0 (0xAA), then sb to line 0x5 byte 1 (0xBB). Expected: count=2, and the tail has wen bits[15:0] set with data[15:0]=0xBBAA.
3. Full: with mem_ready=0, store 4 distinct lines. Expected: st_ready=0. A fifth store to a different line stalls. A fifth store to the tail line merges with st_ready=1.
4. Hazard: with a pending entry for line 0x3, ld_chk_addr=0x3C gives ld_hit=1 and ld_chk_addr=0x40 gives ld_hit=0. After the entry drains, 0x3C gives ld_hit=0.
5. Reset mid-drain: with 3 entries pending and mem_valid=1, assert rst_n=0. Expected: mem_valid=0 immediately, and after release sb_empty=1 and sb_count=0.
6. Simultaneous: with count=2 and mem_ready=1, enqueue a new line on every cycle for 10 cycles. Expected: count stays at 2 and Dmem receives lines in order.

Source files
------------

// File: rtl/u_lsu_store_buffer_pkg.sv
// Shared LSU store-buffer constants: data line width, address width, line geometry and depth.
package u_lsu_store_buffer_pkg;

  localparam int unsigned DATA_MEM_WIDTH     = 128;
  localparam int unsigned DATA_MEM_WIDTH_BIT = 32;
  localparam int unsigned LSU_LINE_OFF_BITS  = 4;
  localparam int unsigned LSU_SB_DEPTH       = 4;

endpackage

// File: rtl/u_lsu_sb_merge.sv
// Combinational bit-merge of a new {data, wen} pair over an older one; new enabled bits win.
module u_lsu_sb_merge
  import u_lsu_store_buffer_pkg::*;
#(
  parameter int unsigned W = DATA_MEM_WIDTH
) (
  input  logic [W-1:0] old_data_i,
  input  logic [W-1:0] old_wen_i,
  input  logic [W-1:0] new_data_i,
  input  logic [W-1:0] new_wen_i,
  output logic [W-1:0] data_o,
  output logic [W-1:0] wen_o
);

  assign data_o = (old_data_i & ~new_wen_i) | (new_data_i & new_wen_i);
  assign wen_o  = old_wen_i | new_wen_i;

endmodule

// File: rtl/u_lsu_store_buffer.sv
// In-order line store buffer: merges same-line stores into the tail, drains the head to Dmem
// and flags loads that hit any pending line.
module u_lsu_store_buffer
  import u_lsu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = LSU_SB_DEPTH,
  parameter int unsigned ADDR_W = DATA_MEM_WIDTH_BIT,
  parameter int unsigned OFF_W  = LSU_LINE_OFF_BITS,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1,
  localparam int unsigned LINE_W = ADDR_W - OFF_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_valid_i,
  output logic                      st_ready_o,
  input  logic [ADDR_W-1:0]         st_addr_i,
  input  logic [DATA_MEM_WIDTH-1:0] st_wr_data_i,
  input  logic [DATA_MEM_WIDTH-1:0] st_wen_i,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic [LINE_W-1:0]         mem_line_o,
  output logic [DATA_MEM_WIDTH-1:0] mem_wr_data_o,
  output logic [DATA_MEM_WIDTH-1:0] mem_wen_o,
  input  logic                      ld_chk_valid_i,
  input  logic [ADDR_W-1:0]         ld_chk_addr_i,
  output logic                      ld_hit_o,
  output logic                      sb_empty_o,
  output logic [CNT_W-1:0]          sb_count_o
);

  logic [LINE_W-1:0]         line_q [DEPTH];
  logic [DATA_MEM_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_MEM_WIDTH-1:0] wen_q  [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [CNT_W-1:0]          count_q, count_d;

  logic [LINE_W-1:0]         st_line, ld_line;
  logic                      merge_elig, st_fire, st_nz, do_alloc, do_merge, do_deq;
  logic [DATA_MEM_WIDTH-1:0] merged_data, merged_wen;
  logic [PTR_W-1:0]          off;
  logic                      hit;
  logic                      unused_low_bits;

  assign unused_low_bits = ^{st_addr_i[OFF_W-1:0], ld_chk_addr_i[OFF_W-1:0]};

  assign st_line  = st_addr_i[ADDR_W-1:OFF_W];
  assign ld_line  = ld_chk_addr_i[ADDR_W-1:OFF_W];
  assign tail_ptr = wr_ptr_q - PTR_W'(1);

  // count >= 2 guarantees the tail is never the head being presented to Dmem.
  assign merge_elig = (count_q >= CNT_W'(2)) && (line_q[tail_ptr] == st_line);
  assign st_ready_o = (count_q < CNT_W'(DEPTH)) || merge_elig;
  assign st_fire    = st_valid_i && st_ready_o;
  assign st_nz      = |st_wen_i;
  assign do_merge   = st_fire && st_nz && merge_elig;
  assign do_alloc   = st_fire && st_nz && !merge_elig;

  assign mem_valid_o   = (count_q != '0);
  assign mem_line_o    = line_q[rd_ptr_q];
  assign mem_wr_data_o = data_q[rd_ptr_q];
  assign mem_wen_o     = wen_q[rd_ptr_q];
  assign do_deq        = mem_valid_o && mem_ready_i;

  assign sb_empty_o = (count_q == '0);
  assign sb_count_o = count_q;

  u_lsu_sb_merge #(
    .W (DATA_MEM_WIDTH)
  ) u_merge (
    .old_data_i (data_q[tail_ptr]),
    .old_wen_i  (wen_q[tail_ptr]),
    .new_data_i (st_wr_data_i),
    .new_wen_i  (st_wen_i),
    .data_o     (merged_data),
    .wen_o      (merged_wen)
  );

  always_comb begin
    count_d = count_q;
    if (do_alloc && !do_deq) count_d = count_q + CNT_W'(1);
    if (!do_alloc && do_deq) count_d = count_q - CNT_W'(1);
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (line_q[i] == ld_line)) hit = 1'b1;
    end
  end

  assign ld_hit_o = ld_chk_valid_i && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
        data_q[i] <= '0;
        wen_q[i]  <= '0;
      end
    end else begin
      if (do_alloc) begin
        line_q[wr_ptr_q] <= st_line;
        data_q[wr_ptr_q] <= st_wr_data_i;
        wen_q[wr_ptr_q]  <= st_wen_i;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (do_merge) begin
        data_q[tail_ptr] <= merged_data;
        wen_q[tail_ptr]  <= merged_wen;
      end
      if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_u_lsu_store_buffer.sv
// Directed bench for the LSU store buffer: vector table plus hand sequences for multi-cycle cases.
module tb_u_lsu_store_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_valid;
  logic         st_ready;
  logic [31:0]  st_addr;
  logic [127:0] st_wr_data;
  logic [127:0] st_wen;
  logic         mem_valid;
  logic         mem_ready;
  logic [27:0]  mem_line;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_wen;
  logic         ld_chk_valid;
  logic [31:0]  ld_chk_addr;
  logic         ld_hit;
  logic         sb_empty;
  logic [2:0]   sb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  u_lsu_store_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .st_valid_i     (st_valid),
    .st_ready_o     (st_ready),
    .st_addr_i      (st_addr),
    .st_wr_data_i   (st_wr_data),
    .st_wen_i       (st_wen),
    .mem_valid_o    (mem_valid),
    .mem_ready_i    (mem_ready),
    .mem_line_o     (mem_line),
    .mem_wr_data_o  (mem_wr_data),
    .mem_wen_o      (mem_wen),
    .ld_chk_valid_i (ld_chk_valid),
    .ld_chk_addr_i  (ld_chk_addr),
    .ld_hit_o       (ld_hit),
    .sb_empty_o     (sb_empty),
    .sb_count_o     (sb_count)
  );

  typedef struct {
    logic         st_v;
    logic [31:0]  st_a;
    logic [127:0] wen;
    logic         mem_rdy;
    logic         ld_v;
    logic [31:0]  ld_a;
    logic         e_rdy;   // st_ready before the edge
    logic         e_hit;   // ld_hit before the edge
    logic [2:0]   e_cnt;   // count after the edge
    logic [27:0]  e_line;  // head line after the edge, if non-empty
  } vec_t;

  localparam logic [127:0] W63_32 = 128'hFFFF_FFFF_0000_0000;
  localparam logic [127:0] DPAT   = {4{32'h1234_5678}};

  vec_t tv [17];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [127:0] w,
                       input logic [127:0] d, input logic r);
    st_valid   = v;
    st_addr    = a;
    st_wen     = w;
    st_wr_data = d;
    mem_ready  = r;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0);
    ld_chk_valid = 1'b0;
    ld_chk_addr  = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] hold_data, hold_wen;
  logic [27:0]  hold_line;
  logic [27:0]  exp_q [$];

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    check("reset_mem_valid", {127'b0, mem_valid}, 128'd0);
    check("reset_st_ready", {127'b0, st_ready}, 128'd1);
    check("reset_sb_empty", {127'b0, sb_empty}, 128'd1);
    check("reset_sb_count", {125'b0, sb_count}, 128'd0);
    ld_chk_valid = 1'b1;
    ld_chk_addr  = 32'h0;
    #1;
    check("reset_ld_hit", {127'b0, ld_hit}, 128'd0);
    idle();
    rst_n = 1'b1;
    tick();

    tv[0]  = '{1'b1, 32'h24, W63_32,          1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd1, 28'h2};
    tv[1]  = '{1'b0, 32'h0,  128'h0,          1'b0, 1'b1, 32'h2C, 1'b1, 1'b1, 3'd1, 28'h2};
    tv[2]  = '{1'b1, 32'h30, 128'hFF,         1'b0, 1'b1, 32'h3C, 1'b1, 1'b0, 3'd2, 28'h2};
    tv[3]  = '{1'b0, 32'h0,  128'h0,          1'b0, 1'b1, 32'h3C, 1'b1, 1'b1, 3'd2, 28'h2};
    tv[4]  = '{1'b1, 32'h38, 128'hFF00,       1'b0, 1'b0, 32'h24, 1'b1, 1'b0, 3'd2, 28'h2};
    tv[5]  = '{1'b1, 32'h40, 128'hFF,         1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd3, 28'h2};
    tv[6]  = '{1'b1, 32'h50, 128'hFF,         1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd4, 28'h2};
    tv[7]  = '{1'b1, 32'h60, 128'hFF,         1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 3'd4, 28'h2};
    tv[8]  = '{1'b1, 32'h5F, 128'hFF00,       1'b0, 1'b1, 32'h50, 1'b1, 1'b1, 3'd4, 28'h2};
    tv[9]  = '{1'b1, 32'h60, 128'hFF,         1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 3'd3, 28'h3};
    tv[10] = '{1'b1, 32'h60, 128'hFF,         1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 3'd3, 28'h4};
    tv[11] = '{1'b1, 32'h70, 128'h0,          1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 3'd2, 28'h5};
    tv[12] = '{1'b0, 32'h0,  128'h0,          1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 3'd1, 28'h6};
    tv[13] = '{1'b0, 32'h0,  128'h0,          1'b1, 1'b1, 32'h60, 1'b1, 1'b1, 3'd0, 28'h0};
    tv[14] = '{1'b1, 32'h80, 128'hFF,         1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd1, 28'h8};
    tv[15] = '{1'b1, 32'h84, 128'hFF0,        1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 3'd2, 28'h8};
    tv[16] = '{1'b1, 32'h88, 128'hFF000000,   1'b0, 1'b1, 32'h8C, 1'b1, 1'b1, 3'd2, 28'h8};

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].st_v, tv[i].st_a, tv[i].wen, DPAT, tv[i].mem_rdy);
      ld_chk_valid = tv[i].ld_v;
      ld_chk_addr  = tv[i].ld_a;
      #1;
      check($sformatf("v%0d_st_ready", i), {127'b0, st_ready}, {127'b0, tv[i].e_rdy});
      check($sformatf("v%0d_ld_hit", i), {127'b0, ld_hit}, {127'b0, tv[i].e_hit});
      tick();
      check($sformatf("v%0d_count", i), {125'b0, sb_count}, {125'b0, tv[i].e_cnt});
      check($sformatf("v%0d_mem_valid", i), {127'b0, mem_valid}, {127'b0, tv[i].e_cnt != 3'd0});
      if (tv[i].e_cnt != 3'd0)
        check($sformatf("v%0d_mem_line", i), {100'b0, mem_line}, {100'b0, tv[i].e_line});
    end

    // Single store held off by Dmem for three cycles, then drained.
    do_reset();
    drive(1'b1, 32'h24, W63_32, {4{32'hDEADBEEF}}, 1'b0);
    tick();
    idle();
    check("single_mem_valid", {127'b0, mem_valid}, 128'd1);
    check("single_mem_line", {100'b0, mem_line}, 128'h2);
    check("single_mem_wen", mem_wen, W63_32);
    check("single_mem_data", mem_wr_data, {4{32'hDEADBEEF}});
    hold_line = mem_line;
    hold_data = mem_wr_data;
    hold_wen  = mem_wen;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hold%0d_valid", c), {127'b0, mem_valid}, 128'd1);
      check($sformatf("hold%0d_line", c), {100'b0, mem_line}, {100'b0, hold_line});
      check($sformatf("hold%0d_data", c), mem_wr_data, hold_data);
      check($sformatf("hold%0d_wen", c), mem_wen, hold_wen);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("single_drained_empty", {127'b0, sb_empty}, 128'd1);
    check("single_drained_valid", {127'b0, mem_valid}, 128'd0);

    // Byte merges into the tail of line 5 behind line 1.
    do_reset();
    drive(1'b1, 32'h10, 128'hFF, {16{8'h11}}, 1'b0);
    tick();
    drive(1'b1, 32'h50, 128'hFF, {16{8'hAA}}, 1'b0);
    tick();
    drive(1'b1, 32'h51, 128'hFF00, {16{8'hBB}}, 1'b0);
    tick();
    idle();
    check("merge_count", {125'b0, sb_count}, 128'd2);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("merge_head_line", {100'b0, mem_line}, 128'h5);
    check("merge_head_wen", mem_wen, 128'hFFFF);
    check("merge_head_data_lo", {112'b0, mem_wr_data[15:0]}, 128'hBBAA);

    // Reset while three entries are pending.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100 + 32'(k) * 32'h10, 128'hF, DPAT, 1'b0);
      tick();
    end
    idle();
    check("rst_pre_count", {125'b0, sb_count}, 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {127'b0, mem_valid}, 128'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_post_empty", {127'b0, sb_empty}, 128'd1);
    check("rst_post_count", {125'b0, sb_count}, 128'd0);

    // Concurrent enqueue and drain at count 2 for ten cycles.
    do_reset();
    exp_q.delete();
    drive(1'b1, 32'h100, 128'hF, DPAT, 1'b0);
    exp_q.push_back(28'h10);
    tick();
    drive(1'b1, 32'h110, 128'hF, DPAT, 1'b0);
    exp_q.push_back(28'h11);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, (32'h20 + 32'(k)) << 4, 128'hF0, DPAT, 1'b1);
      #1;
      check($sformatf("sim%0d_st_ready", k), {127'b0, st_ready}, 128'd1);
      check($sformatf("sim%0d_line", k), {100'b0, mem_line}, {100'b0, exp_q[0]});
      void'(exp_q.pop_front());
      exp_q.push_back(28'h20 + 28'(k));
      tick();
      check($sformatf("sim%0d_count", k), {125'b0, sb_count}, 128'd2);
    end
    idle();
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("simdrain%0d_line", k), {100'b0, mem_line}, {100'b0, exp_q[0]});
      void'(exp_q.pop_front());
      tick();
    end
    check("sim_final_empty", {127'b0, sb_empty}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
